// File: rtl/triangle_setup_if.sv
// rtl/triangle_setup_if.sv - vertex input and setup-triangle output bundle for triangle_setup
// master drives vertices and accepts triangles; slave is the setup stage.
interface triangle_setup_if;
  logic        vtx_valid;
  logic        vtx_ready;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        prim_restart;
  logic        tri_valid;
  logic        tri_ready;
  logic [15:0] v0_x;
  logic [15:0] v0_y;
  logic [15:0] v1_x;
  logic [15:0] v1_y;
  logic [15:0] v2_x;
  logic [15:0] v2_y;
  logic [15:0] bb_xmin;
  logic [15:0] bb_xmax;
  logic [15:0] bb_ymin;
  logic [15:0] bb_ymax;
  logic [34:0] area;
  logic [15:0] cull_count;

  modport master (
    output vtx_valid, x_in, y_in, prim_restart, tri_ready,
    input  vtx_ready, tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y,
           bb_xmin, bb_xmax, bb_ymin, bb_ymax, area, cull_count
  );

  modport slave (
    input  vtx_valid, x_in, y_in, prim_restart, tri_ready,
    output vtx_ready, tri_valid, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y,
           bb_xmin, bb_xmax, bb_ymin, bb_ymax, area, cull_count
  );
endinterface

// File: rtl/triangle_setup.sv
// rtl/triangle_setup.sv - primitive assembly and triangle setup stage
// Collects three vertices, computes doubled area and screen bbox, culls, emits.
module triangle_setup #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int CULL_BACK = 1
) (
  input  logic            clk,
  input  logic            reset,
  triangle_setup_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETUP   = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic signed [15:0] vx_q [0:2];
  logic signed [15:0] vx_d [0:2];
  logic signed [15:0] vy_q [0:2];
  logic signed [15:0] vy_d [0:2];
  logic [34:0]        area_q, area_d;
  logic [15:0]        bb_xmin_q, bb_xmin_d;
  logic [15:0]        bb_xmax_q, bb_xmax_d;
  logic [15:0]        bb_ymin_q, bb_ymin_d;
  logic [15:0]        bb_ymax_q, bb_ymax_d;
  logic               tri_valid_q, tri_valid_d;
  logic [15:0]        cull_q, cull_d;

  logic [1:0]         slot;
  logic signed [15:0] sat_x, sat_y;
  logic signed [16:0] dx1, dy1, dx2, dy2;
  logic signed [33:0] prod_a, prod_b;
  logic signed [34:0] area_calc;
  logic signed [15:0] min_x, max_x, min_y, max_y;
  logic               off_screen;
  logic               cull;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [15:0] clamp(input logic signed [15:0] v, input int hi);
    if (v[15])
      return 16'd0;
    else if (int'(v) > hi)
      return 16'(hi);
    else
      return v;
  endfunction

  // Setup arithmetic works on the stored, already saturated vertices.
  always_comb begin
    sat_x     = sat16(bus.x_in);
    sat_y     = sat16(bus.y_in);
    dx1       = {vx_q[1][15], vx_q[1]} - {vx_q[0][15], vx_q[0]};
    dy1       = {vy_q[1][15], vy_q[1]} - {vy_q[0][15], vy_q[0]};
    dx2       = {vx_q[2][15], vx_q[2]} - {vx_q[0][15], vx_q[0]};
    dy2       = {vy_q[2][15], vy_q[2]} - {vy_q[0][15], vy_q[0]};
    prod_a    = 34'(dx1) * 34'(dy2);
    prod_b    = 34'(dx2) * 34'(dy1);
    area_calc = 35'(prod_a) - 35'(prod_b);
    min_x     = min3(vx_q[0], vx_q[1], vx_q[2]);
    max_x     = max3(vx_q[0], vx_q[1], vx_q[2]);
    min_y     = min3(vy_q[0], vy_q[1], vy_q[2]);
    max_y     = max3(vy_q[0], vy_q[1], vy_q[2]);
    off_screen = max_x[15] || (int'(min_x) > SCREEN_W - 1) ||
                 max_y[15] || (int'(min_y) > SCREEN_H - 1);
    cull = (area_calc == 35'sd0) || ((CULL_BACK != 0) && area_calc[34]) || off_screen;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    area_d      = area_q;
    bb_xmin_d   = bb_xmin_q;
    bb_xmax_d   = bb_xmax_q;
    bb_ymin_d   = bb_ymin_q;
    bb_ymax_d   = bb_ymax_q;
    tri_valid_d = tri_valid_q;
    cull_d      = cull_q;
    slot        = bus.prim_restart ? 2'd0 : cnt_q;

    case (state_q)
      COLLECT: begin
        if (bus.prim_restart)
          cnt_d = 2'd0;
        if (bus.vtx_valid) begin
          case (slot)
            2'd0:    begin vx_d[0] = sat_x; vy_d[0] = sat_y; end
            2'd1:    begin vx_d[1] = sat_x; vy_d[1] = sat_y; end
            default: begin vx_d[2] = sat_x; vy_d[2] = sat_y; end
          endcase
          if (slot == 2'd2) begin
            cnt_d   = 2'd0;
            state_d = SETUP;
          end else begin
            cnt_d = slot + 2'd1;
          end
        end
      end
      SETUP: begin
        area_d    = area_calc;
        bb_xmin_d = clamp(min_x, SCREEN_W - 1);
        bb_xmax_d = clamp(max_x, SCREEN_W - 1);
        bb_ymin_d = clamp(min_y, SCREEN_H - 1);
        bb_ymax_d = clamp(max_y, SCREEN_H - 1);
        if (cull) begin
          state_d = COLLECT;
          if (cull_q != 16'hffff)
            cull_d = cull_q + 16'd1;
        end else begin
          state_d     = EMIT;
          tri_valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (bus.tri_ready) begin
          state_d     = COLLECT;
          tri_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = COLLECT;
        tri_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      area_q      <= '0;
      bb_xmin_q   <= '0;
      bb_xmax_q   <= '0;
      bb_ymin_q   <= '0;
      bb_ymax_q   <= '0;
      tri_valid_q <= 1'b0;
      cull_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      area_q      <= area_d;
      bb_xmin_q   <= bb_xmin_d;
      bb_xmax_q   <= bb_xmax_d;
      bb_ymin_q   <= bb_ymin_d;
      bb_ymax_q   <= bb_ymax_d;
      tri_valid_q <= tri_valid_d;
      cull_q      <= cull_d;
    end
  end

  // Only combinational output: ready is held low while reset is asserted.
  assign bus.vtx_ready  = (state_q == COLLECT) && !reset;
  assign bus.tri_valid  = tri_valid_q;
  assign bus.v0_x       = vx_q[0];
  assign bus.v0_y       = vy_q[0];
  assign bus.v1_x       = vx_q[1];
  assign bus.v1_y       = vy_q[1];
  assign bus.v2_x       = vx_q[2];
  assign bus.v2_y       = vy_q[2];
  assign bus.bb_xmin    = bb_xmin_q;
  assign bus.bb_xmax    = bb_xmax_q;
  assign bus.bb_ymin    = bb_ymin_q;
  assign bus.bb_ymax    = bb_ymax_q;
  assign bus.area       = area_q;
  assign bus.cull_count = cull_q;

endmodule

// File: tb/tb_triangle_setup.sv
// tb/tb_triangle_setup.sv - self-checking bench for triangle_setup
// dut_a culls back faces, dut_b does not; a triangle-level model predicts both.
module tb_triangle_setup;
  localparam int W = 640;
  localparam int H = 480;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        vv    = 1'b0;
  logic        rs    = 1'b0;
  logic        tr    = 1'b1;
  logic [31:0] xin   = '0;
  logic [31:0] yin   = '0;
  int          sel   = 0;

  triangle_setup_if if_a();
  triangle_setup_if if_b();

  assign if_a.vtx_valid    = vv && (sel == 0);
  assign if_b.vtx_valid    = vv && (sel == 1);
  assign if_a.prim_restart = rs && (sel == 0);
  assign if_b.prim_restart = rs && (sel == 1);
  assign if_a.x_in = xin;
  assign if_b.x_in = xin;
  assign if_a.y_in = yin;
  assign if_b.y_in = yin;
  assign if_a.tri_ready = tr;
  assign if_b.tri_ready = tr;

  triangle_setup #(.SCREEN_W(W), .SCREEN_H(H), .CULL_BACK(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  triangle_setup #(.SCREEN_W(W), .SCREEN_H(H), .CULL_BACK(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));

  always #5 clk = ~clk;

  typedef struct {
    int     v0x, v0y, v1x, v1y, v2x, v2y;
    longint area;
    int     xmin, xmax, ymin, ymax;
  } tri_t;

  tri_t q0[$];
  tri_t q1[$];
  int   pn[2];
  int   px[2][3];
  int   py[2][3];
  int   ccnt[2];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- model ----------------
  function automatic int sat(input logic signed [31:0] v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int cl(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int mn(input int a, input int b, input int c);
    int m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int mx(input int a, input int b, input int c);
    int m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  task automatic model_accept(input int s, input logic [31:0] x, input logic [31:0] y, input bit r);
    tri_t t;
    int minx, maxx, miny, maxy;
    bit drop;
    if (r) pn[s] = 0;
    px[s][pn[s]] = sat(x);
    py[s][pn[s]] = sat(y);
    pn[s]++;
    if (pn[s] < 3) return;
    pn[s] = 0;
    t.v0x = px[s][0]; t.v0y = py[s][0];
    t.v1x = px[s][1]; t.v1y = py[s][1];
    t.v2x = px[s][2]; t.v2y = py[s][2];
    t.area = longint'(t.v1x - t.v0x) * longint'(t.v2y - t.v0y)
           - longint'(t.v2x - t.v0x) * longint'(t.v1y - t.v0y);
    minx = mn(t.v0x, t.v1x, t.v2x); maxx = mx(t.v0x, t.v1x, t.v2x);
    miny = mn(t.v0y, t.v1y, t.v2y); maxy = mx(t.v0y, t.v1y, t.v2y);
    t.xmin = cl(minx, W - 1); t.xmax = cl(maxx, W - 1);
    t.ymin = cl(miny, H - 1); t.ymax = cl(maxy, H - 1);
    drop = (t.area == 0) || (s == 0 && t.area < 0) ||
           maxx < 0 || minx > W - 1 || maxy < 0 || miny > H - 1;
    if (drop) begin
      if (ccnt[s] < 65535) ccnt[s]++;
    end else if (s == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    pn[0] = 0; pn[1] = 0;
    ccnt[0] = 0; ccnt[1] = 0;
  endtask

  // ---------------- DUT access ----------------
  function automatic bit tv(input int s);
    return (s == 0) ? if_a.tri_valid : if_b.tri_valid;
  endfunction

  function automatic bit vr(input int s);
    return (s == 0) ? if_a.vtx_ready : if_b.vtx_ready;
  endfunction

  function automatic int cc(input int s);
    return (s == 0) ? int'(if_a.cull_count) : int'(if_b.cull_count);
  endfunction

  function automatic tri_t dut_tri(input int s);
    tri_t t;
    if (s == 0) begin
      t.v0x = int'($signed(if_a.v0_x)); t.v0y = int'($signed(if_a.v0_y));
      t.v1x = int'($signed(if_a.v1_x)); t.v1y = int'($signed(if_a.v1_y));
      t.v2x = int'($signed(if_a.v2_x)); t.v2y = int'($signed(if_a.v2_y));
      t.area = longint'($signed(if_a.area));
      t.xmin = int'(if_a.bb_xmin); t.xmax = int'(if_a.bb_xmax);
      t.ymin = int'(if_a.bb_ymin); t.ymax = int'(if_a.bb_ymax);
    end else begin
      t.v0x = int'($signed(if_b.v0_x)); t.v0y = int'($signed(if_b.v0_y));
      t.v1x = int'($signed(if_b.v1_x)); t.v1y = int'($signed(if_b.v1_y));
      t.v2x = int'($signed(if_b.v2_x)); t.v2y = int'($signed(if_b.v2_y));
      t.area = longint'($signed(if_b.area));
      t.xmin = int'(if_b.bb_xmin); t.xmax = int'(if_b.bb_xmax);
      t.ymin = int'(if_b.bb_ymin); t.ymax = int'(if_b.bb_ymax);
    end
    return t;
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  task automatic compare_dut(input int s);
    tri_t d, e;
    bit have;
    if (reset || !tv(s)) return;
    check($sformatf("vtx_ready_in_emit[%0d]", s), vr(s), 0);
    have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (!have) begin
      check($sformatf("unexpected_tri_valid[%0d]", s), 1, 0);
      return;
    end
    e = (s == 0) ? q0[0] : q1[0];
    d = dut_tri(s);
    check($sformatf("v0_x[%0d]", s), d.v0x, e.v0x);
    check($sformatf("v0_y[%0d]", s), d.v0y, e.v0y);
    check($sformatf("v1_x[%0d]", s), d.v1x, e.v1x);
    check($sformatf("v1_y[%0d]", s), d.v1y, e.v1y);
    check($sformatf("v2_x[%0d]", s), d.v2x, e.v2x);
    check($sformatf("v2_y[%0d]", s), d.v2y, e.v2y);
    check($sformatf("area[%0d]", s), d.area, e.area);
    check($sformatf("bb_xmin[%0d]", s), d.xmin, e.xmin);
    check($sformatf("bb_xmax[%0d]", s), d.xmax, e.xmax);
    check($sformatf("bb_ymin[%0d]", s), d.ymin, e.ymin);
    check($sformatf("bb_ymax[%0d]", s), d.ymax, e.ymax);
  endtask

  always @(negedge clk) begin
    compare_dut(0);
    compare_dut(1);
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (if_a.tri_valid && tr && q0.size() > 0) void'(q0.pop_front());
      if (if_b.tri_valid && tr && q1.size() > 0) void'(q1.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int s, input logic [31:0] x, input logic [31:0] y, input bit r);
    int t = 0;
    @(negedge clk);
    sel = s; xin = x; yin = y; rs = r; vv = 1'b1;
    while (!vr(s) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("vtx_ready_timeout", 0, 1);
    else begin
      @(posedge clk);
      model_accept(s, x, y, r);
    end
    #1;
    vv = 1'b0; rs = 1'b0;
  endtask

  task automatic send_tri(input int s, input int x0, input int y0, input int x1,
                          input int y1, input int x2, input int y2);
    send(s, x0, y0, 1'b0);
    send(s, x1, y1, 1'b0);
    send(s, x2, y2, 1'b0);
  endtask

  // Called right after the third vertex edge N: SETUP in N+1, result after N+2.
  task automatic latency(input int s, input bit emit, input string name);
    @(negedge clk);
    check({name, "_setup_tv"}, tv(s), 0);
    check({name, "_setup_ready"}, vr(s), 0);
    @(negedge clk);
    check({name, "_tv"}, tv(s), emit);
    check({name, "_ready"}, vr(s), !emit);
  endtask

  task automatic wait_idle(input int s);
    int t = 0;
    @(negedge clk);
    while ((tv(s) || !vr(s)) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("idle_timeout", 0, 1);
  endtask

  task automatic check_cull();
    check("cull_count[0]", cc(0), ccnt[0]);
    check("cull_count[1]", cc(1), ccnt[1]);
  endtask

  initial begin
    tri_t d;
    model_reset();
    #1;
    check("reset_vtx_ready", vr(0), 0);
    check("reset_tri_valid", tv(0), 0);
    check("reset_area", longint'(if_a.area), 0);
    check("reset_cull", cc(0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("post_reset_ready", vr(0), 1);

    // Front-facing
    send_tri(0, 10, 10, 50, 10, 10, 40);
    latency(0, 1, "front");
    d = dut_tri(0);
    check("front_area", d.area, 1200);
    check("front_xmin", d.xmin, 10);
    check("front_xmax", d.xmax, 50);
    check("front_ymin", d.ymin, 10);
    check("front_ymax", d.ymax, 40);
    wait_idle(0);
    check("front_cull", cc(0), 0);

    // Back-facing: culled on dut_a, emitted on dut_b
    send_tri(0, 10, 10, 10, 40, 50, 10);
    latency(0, 0, "back_a");
    check("back_cull", cc(0), 1);
    send_tri(1, 10, 10, 10, 40, 50, 10);
    latency(1, 1, "back_b");
    check("back_b_area", dut_tri(1).area, -1200);
    wait_idle(1);

    // Saturation and clamp
    send_tri(1, 32'h0001_0000, 5, 0, 5, 0, 100);
    latency(1, 1, "sat");
    d = dut_tri(1);
    check("sat_v0x", d.v0x, 32767);
    check("sat_area", d.area, -3112865);
    check("sat_xmin", d.xmin, 0);
    check("sat_xmax", d.xmax, 639);
    check("sat_ymin", d.ymin, 5);
    check("sat_ymax", d.ymax, 100);
    wait_idle(1);
    send_tri(1, 32'h8000_0000, 32'h7fff_ffff, 1, 2, 3, 4);
    wait_idle(1);
    check_cull();

    // Off-screen, degenerate, screen edges
    send_tri(0, -100, 0, -50, 0, -100, 30);
    latency(0, 0, "off_left");
    send_tri(0, 0, 0, 5, 5, 10, 10);
    latency(0, 0, "collinear");
    check("collinear_cull", cc(0), 3);
    send_tri(0, 700, 10, 800, 10, 700, 50);
    wait_idle(0);
    send_tri(0, 10, 480, 50, 480, 10, 500);
    wait_idle(0);
    check("off_edges_cull", cc(0), 5);
    send_tri(0, 639, 0, 700, 0, 639, 10);
    latency(0, 1, "edge");
    d = dut_tri(0);
    check("edge_area", d.area, 610);
    check("edge_xmin", d.xmin, 639);
    check("edge_xmax", d.xmax, 639);
    wait_idle(0);
    check_cull();

    // Backpressure
    tr = 1'b0;
    send_tri(0, 10, 10, 50, 10, 10, 40);
    latency(0, 1, "bp");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_hold_tv", tv(0), 1);
      check("bp_hold_ready", vr(0), 0);
      check("bp_hold_area", dut_tri(0).area, 1200);
    end
    tr = 1'b1;
    @(negedge clk);
    check("bp_drop_tv", tv(0), 0);
    check("bp_ready", vr(0), 1);

    // Restart
    send(0, 1, 1, 1'b0);
    send(0, 2, 2, 1'b0);
    send(0, 10, 10, 1'b1);
    send(0, 50, 10, 1'b0);
    send(0, 10, 40, 1'b0);
    latency(0, 1, "restart");
    d = dut_tri(0);
    check("restart_v0x", d.v0x, 10);
    check("restart_v0y", d.v0y, 10);
    check("restart_area", d.area, 1200);
    wait_idle(0);
    check_cull();

    // Reset mid-EMIT
    tr = 1'b0;
    send_tri(0, 10, 10, 50, 10, 10, 40);
    latency(0, 1, "pre_reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_tv", tv(0), 0);
    check("rst_area", longint'(if_a.area), 0);
    check("rst_v0x", int'(if_a.v0_x), 0);
    check("rst_xmax", int'(if_a.bb_xmax), 0);
    check("rst_cull", cc(0), 0);
    check("rst_ready", vr(0), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tr = 1'b1;
    #1 check("rst_release_ready", vr(0), 1);
    repeat (3) @(negedge clk);
    check("rst_no_emit", tv(0), 0);

    // Reset mid-triangle
    send(1, 7, 7, 1'b0);
    send(1, 8, 9, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send_tri(1, 10, 10, 50, 10, 10, 40);
    latency(1, 1, "after_rst");
    check("after_rst_v0x", dut_tri(1).v0x, 10);
    wait_idle(1);
    check_cull();

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
